// File: rtl/alu_program_sequencer.sv
// Programmable instruction sequencer driving the alu_regfile datapath.
// Ports: clk/reset, step/run/restart controls, zero_flag in, program write
// port (prog_we/addr/data), decoded instruction fields out, write_en strobe,
// pc and halted status.
module alu_program_sequencer #(
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 3,
  parameter int PC_W    = 4,
  parameter int RUN_DIV = 1,
  localparam int INSTR_W = 2 + 4 + 1 + 3 * SEL_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               run,
  input  logic               restart,
  input  logic               zero_flag,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [SEL_W-1:0]   a_reg,
  output logic [SEL_W-1:0]   b_reg,
  output logic [SEL_W-1:0]   dest_reg,
  output logic [DATA_W-1:0]  immediate,
  output logic               immediate_p,
  output logic [3:0]         alu_op,
  output logic               write_en,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int DEPTH = 2 ** PC_W;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [1:0] C_NEXT = 2'd0;
  localparam logic [1:0] C_JUMP = 2'd1;
  localparam logic [1:0] C_BZ   = 2'd2;
  localparam logic [1:0] C_HALT = 2'd3;

  localparam int A_LSB  = DATA_W;
  localparam int B_LSB  = DATA_W + SEL_W;
  localparam int D_LSB  = DATA_W + 2 * SEL_W;
  localparam int IP_BIT = DATA_W + 3 * SEL_W;
  localparam int OP_LSB = IP_BIT + 1;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_cur;
  logic [PC_W-1:0]    r_pc;
  logic [1:0]         r_state;
  logic               r_step_q;
  logic [DIV_W-1:0]   r_div;

  logic [1:0]      w_ctrl;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_step_rise;
  logic            w_div_hit;
  logic            w_trig;

  assign w_ctrl      = r_cur[INSTR_W-1 -: 2];
  assign w_tgt       = r_cur[PC_W-1:0];
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_step_rise = step & ~r_step_q;
  assign w_div_hit   = run && (r_div == DIV_W'(RUN_DIV - 1));
  // restart overrides a trigger seen in the same cycle
  assign w_trig      = (r_state == S_IDLE) && !restart
                     && (w_step_rise || w_div_hit);

  always_comb begin
    w_pc_nxt = w_pc_inc;
    unique case (w_ctrl)
      C_JUMP:  w_pc_nxt = w_tgt;
      C_BZ:    w_pc_nxt = zero_flag ? w_tgt : w_pc_inc;
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  // Not reset; a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_cur    <= '0;
      r_step_q <= 1'b0;
      r_div    <= '0;
    end else begin
      r_step_q <= step;
      if (!run || w_trig)
        r_div <= '0;
      else if (r_state == S_IDLE)
        r_div <= r_div + DIV_W'(1);
      if (restart) begin
        r_pc    <= '0;
        r_state <= S_FETCH;
      end else begin
        unique case (r_state)
          S_FETCH: begin
            r_cur   <= r_mem[r_pc];
            r_state <= S_IDLE;
          end
          S_IDLE: begin
            if (w_trig)
              r_state <= (w_ctrl == C_HALT) ? S_HALT : S_EXEC;
          end
          S_EXEC: begin
            r_pc    <= w_pc_nxt;
            r_state <= S_FETCH;
          end
          S_HALT: r_state <= S_HALT;
        endcase
      end
    end
  end

  assign a_reg       = r_cur[A_LSB +: SEL_W];
  assign b_reg       = r_cur[B_LSB +: SEL_W];
  assign dest_reg    = r_cur[D_LSB +: SEL_W];
  assign immediate   = r_cur[DATA_W-1:0];
  assign immediate_p = r_cur[IP_BIT];
  assign alu_op      = r_cur[OP_LSB +: 4];
  assign write_en    = (r_state == S_EXEC);
  assign halted      = (r_state == S_HALT);
  assign pc          = r_pc;

  logic w_unused;
  assign w_unused = ^{C_NEXT};

endmodule
